// File: rtl/seq_gen_arbiter.sv
// Round-robin arbiter that grants one requester at a time and plays the fixed
// code sequence 0,2,5,3,4 on seq_out for the granted requester, pulsing done at the end of each pass.
module seq_gen_arbiter #(
    parameter int NREQ = 4,
    parameter int SW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    output logic [NREQ-1:0] gnt,
    output logic [SW-1:0]   seq_out,
    output logic            seq_valid,
    output logic            done,
    output logic            busy
);

    localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SW-1:0] LAST_CODE = SW'(4);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] winner;
    logic          any_req;
    logic          owner_req;
    logic          at_last;

    function automatic logic [SW-1:0] next_code(input logic [SW-1:0] c);
        logic [2:0] n;
        case (c)
            SW'(0):  n = 3'd2;
            SW'(2):  n = 3'd5;
            SW'(5):  n = 3'd3;
            SW'(3):  n = 3'd4;
            default: n = 3'd0;
        endcase
        return SW'(n);
    endfunction

    // Scanning from the farthest candidate down lets the nearest requester after
    // last win, which also makes the just-served requester the lowest priority.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW:0]   cand;
        logic [IW-1:0] win;
        win = last;
        for (int i = NREQ; i >= 1; i--) begin
            cand = {1'b0, last} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (r[cand[IW-1:0]])
                win = cand[IW-1:0];
        end
        return win;
    endfunction

    assign any_req   = |req;
    assign owner_req = |(req & gnt);
    assign at_last   = (seq_out == LAST_CODE);
    assign winner    = rr_pick(req, last_gnt);
    assign busy      = (state == RUN);
    assign done      = ~rst & busy & at_last & ~hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            seq_out   <= '0;
            seq_valid <= 1'b0;
            last_gnt  <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= RUN;
                        gnt       <= NREQ'(1) << winner;
                        seq_out   <= '0;
                        seq_valid <= 1'b1;
                        last_gnt  <= winner;
                    end
                end
                RUN: begin
                    // Abandon wins over hold; a drop on the final code still completes the pass.
                    if (!owner_req && !at_last) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        seq_out   <= '0;
                        seq_valid <= 1'b0;
                    end else if (hold) begin
                        state <= RUN;
                    end else if (at_last) begin
                        if (any_req) begin
                            gnt       <= NREQ'(1) << winner;
                            seq_out   <= '0;
                            seq_valid <= 1'b1;
                            last_gnt  <= winner;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            seq_out   <= '0;
                            seq_valid <= 1'b0;
                        end
                    end else begin
                        seq_out <= next_code(seq_out);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    seq_out   <= '0;
                    seq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Bench for seq_gen_arbiter: directed scenarios plus random traffic, compared
// each cycle against a pass/position reference model of the arbiter.
module tb_seq_gen_arbiter;

    localparam int NREQ = 4;
    localparam int SW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            hold;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   seq_out;
    logic            seq_valid;
    logic            done;
    logic            busy;

    seq_gen_arbiter #(.NREQ(NREQ), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .hold      (hold),
        .gnt       (gnt),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: is a pass active, who owns it, how far along the code list it is.
    bit m_active;
    int m_owner;
    int m_pos;
    int m_last;
    int codes[5] = '{0, 2, 5, 3, 4};

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] sh;
        for (int i = 1; i <= NREQ; i++) begin
            sh = r >> ((last + i) % NREQ);
            if (sh[0]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_pos    = 0;
        m_last   = NREQ - 1;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic h);
        logic [NREQ-1:0] sh;
        int w;
        w = pick(r, m_last);
        if (!m_active) begin
            if (w >= 0) begin
                m_active = 1'b1; m_owner = w; m_pos = 0; m_last = w;
            end
        end else begin
            sh = r >> m_owner;
            if (!sh[0] && m_pos != 4) begin
                m_active = 1'b0;
            end else if (h) begin
                m_active = 1'b1;
            end else if (m_pos == 4) begin
                if (w >= 0) begin
                    m_owner = w; m_pos = 0; m_last = w;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("gnt",       32'(gnt),       m_active ? 32'(1 << m_owner) : 32'd0);
        check("seq_out",   32'(seq_out),   m_active ? 32'(codes[m_pos]) : 32'd0);
        check("seq_valid", 32'(seq_valid), 32'(m_active));
        check("busy",      32'(busy),      32'(m_active));
        check("done",      32'(done),      32'(m_active && m_pos == 4 && !hold));
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic h);
        req  = r;
        hold = h;
        #1;
        check_outputs();
        model_edge(r, h);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        rst  = 1'b1;
        req  = '0;
        hold = 1'b0;
        @(negedge clk);

        phase = "reset";
        do_reset();

        phase = "single";
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);

        phase = "round_robin";
        do_reset();
        for (int i = 0; i < 26; i++) step(4'b1111, 1'b0);

        phase = "hold";
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);

        phase = "abandon";
        do_reset();
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        check("abandon_regrant", 32'(gnt), 32'd4);
        step(4'b0100, 1'b0);

        phase = "async_reset";
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        check("pre_rst_seq", 32'(seq_out), 32'd5);
        #1;
        rst = 1'b1;
        req = 4'b1000;
        #1;
        model_reset();
        check_outputs();
        rst = 1'b0;
        step(4'b1000, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'd8);
        step(4'b1000, 1'b0);

        phase = "done_drop";
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        phase = "random";
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, 15));
            step(r, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
